// File: rtl/binary_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// binary_to_bcd_seq
//
// Sequential binary to packed-BCD converter (shift-add-3 / double dabble).
// One adjust+shift iteration per clock, BIN_W iterations per conversion.
// Optional two's complement input (magnitude + NEG flag) and overflow
// detection with saturation of the displayed value to all nines.
//
// Parameters
//   BIN_W   input width in bits (4..32)
//   DIGITS  number of BCD output digits (1..10)
//   SIGNED  1: BIN is two's complement, 0: unsigned
//
// Ports
//   CLK        system clock
//   RST_N      asynchronous active-low reset
//   START      conversion request, sampled only while idle
//   BIN        binary input, captured on the accepting edge only
//   BUSY       high while a conversion is in progress
//   DONE       one-cycle pulse when BCDOUT/NEG/OVF carry a new result
//   BCDOUT     packed BCD, digit i at [4i+3:4i], digit 0 = ones
//   NEG        sign of the last result (always 0 when SIGNED=0)
//   OVF        last magnitude exceeded 10^DIGITS-1 (BCDOUT saturated)
//   DBG_STATE  current FSM state (0 = IDLE, 1 = CONV)
//
// Handshake: START is a level request. While BUSY=0 (IDLE) a high START at a
// rising edge is accepted on that edge and BIN is captured; BUSY rises after
// that edge and falls after BIN_W further edges, on the same edge that DONE
// pulses for one cycle. START while BUSY=1 is ignored (no queueing). The
// cycle in which DONE is high is an IDLE cycle, so START may be accepted then.
// ---------------------------------------------------------------------------
module binary_to_bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5,
  parameter bit SIGNED = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic [BIN_W-1:0]      BIN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [4*DIGITS-1:0]   BCDOUT,
  output logic                  NEG,
  output logic                  OVF,
  output logic                  DBG_STATE
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CONV = 1'b1;

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  // Overflow can only happen when the largest input does not fit in DIGITS
  // decimal digits; otherwise the flag is held at 0.
  localparam bit OVF_EN = (pow10(DIGITS) <= (64'd1 << BIN_W));

  logic [0:0]       state;
  logic [BIN_W-1:0] bin_sr;
  logic [BCD_W-1:0] bcd_sr;
  logic [CNT_W-1:0] cnt;
  logic             ovf_acc;
  logic             neg_lat;
  logic             mag_nz;

  logic             bin_neg;
  logic [BIN_W-1:0] mag_in;
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bcd_shift;
  logic [BIN_W-1:0] bin_shift;
  logic             carry;
  logic             ovf_now;

  // Magnitude of the input; for the most-negative value the two's complement
  // is itself, which read as unsigned is the correct magnitude.
  assign bin_neg = SIGNED && BIN[BIN_W-1];
  assign mag_in  = bin_neg ? (~BIN + BIN_W'(1)) : BIN;

  // Add 3 to every digit >= 5 before the shift (max 9+3 = 12, no wrap).
  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
      end
    end
  end

  // {carry, bcd, bin} << 1: the bit leaving the top digit is the overflow carry.
  assign carry     = bcd_adj[BCD_W-1];
  assign bcd_shift = {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
  assign bin_shift = {bin_sr[BIN_W-2:0], 1'b0};
  assign ovf_now   = OVF_EN && (ovf_acc || carry);

  assign DBG_STATE = state;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      bin_sr  <= '0;
      bcd_sr  <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
      neg_lat <= 1'b0;
      mag_nz  <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      BCDOUT  <= '0;
      NEG     <= 1'b0;
      OVF     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            bin_sr  <= mag_in;
            bcd_sr  <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
            neg_lat <= bin_neg;
            mag_nz  <= |BIN;
            BUSY    <= 1'b1;
            state   <= ST_CONV;
          end
        end
        ST_CONV: begin
          bin_sr  <= bin_shift;
          bcd_sr  <= bcd_shift;
          ovf_acc <= ovf_now;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            BCDOUT <= ovf_now ? {DIGITS{4'h9}} : bcd_shift;
            OVF    <= ovf_now;
            NEG    <= neg_lat && mag_nz;
            DONE   <= 1'b1;
            BUSY   <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_binary_to_bcd_seq
//
// Four converter instances:
//   u0  defaults (BIN_W=16, DIGITS=5, unsigned)
//   u1  BIN_W=16, DIGITS=4, unsigned (overflow/saturation)
//   u2  BIN_W=16, DIGITS=5, SIGNED=1
//   u3  BIN_W=8,  DIGITS=3, unsigned (exhaustive sweep)
// u0..u2 share START/BIN and run in lockstep, so every 16-bit vector is
// checked against all three interpretations.
// ---------------------------------------------------------------------------
module tb_binary_to_bcd_seq;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        start16;
  logic [15:0] bin16;
  logic        start8;
  logic [7:0]  bin8;

  logic busy0, done0, neg0, ovf0, dbg0;
  logic [19:0] bcd0;
  logic busy1, done1, neg1, ovf1, dbg1;
  logic [15:0] bcd1;
  logic busy2, done2, neg2, ovf2, dbg2;
  logic [19:0] bcd2;
  logic busy3, done3, neg3, ovf3, dbg3;
  logic [11:0] bcd3;

  int errors = 0;
  int checks = 0;

  binary_to_bcd_seq u0 (
    .CLK(clk), .RST_N(rst_n), .START(start16), .BIN(bin16),
    .BUSY(busy0), .DONE(done0), .BCDOUT(bcd0), .NEG(neg0), .OVF(ovf0),
    .DBG_STATE(dbg0)
  );

  binary_to_bcd_seq #(.BIN_W(16), .DIGITS(4), .SIGNED(1'b0)) u1 (
    .CLK(clk), .RST_N(rst_n), .START(start16), .BIN(bin16),
    .BUSY(busy1), .DONE(done1), .BCDOUT(bcd1), .NEG(neg1), .OVF(ovf1),
    .DBG_STATE(dbg1)
  );

  binary_to_bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(1'b1)) u2 (
    .CLK(clk), .RST_N(rst_n), .START(start16), .BIN(bin16),
    .BUSY(busy2), .DONE(done2), .BCDOUT(bcd2), .NEG(neg2), .OVF(ovf2),
    .DBG_STATE(dbg2)
  );

  binary_to_bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(1'b0)) u3 (
    .CLK(clk), .RST_N(rst_n), .START(start8), .BIN(bin8),
    .BUSY(busy3), .DONE(done3), .BCDOUT(bcd3), .NEG(neg3), .OVF(ovf3),
    .DBG_STATE(dbg3)
  );

  // Decimal reference for the 8-bit sweep (division based).
  function automatic logic [11:0] dec3(input int m);
    logic [11:0] r;
    int          v;
    r = '0;
    v = m;
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Directed vector table: expected results for u0 / u1 / u2.
  typedef struct {
    logic [15:0] bin;
    logic [19:0] e0;
    logic [15:0] e1;
    logic        e1_ovf;
    logic [19:0] e2;
    logic        e2_neg;
  } vec_t;

  task automatic test_reset();
    rst_n   = 1'b0;
    start16 = 1'b0;
    bin16   = '0;
    start8  = 1'b0;
    bin8    = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy0, done0, bcd0, neg0, ovf0} !== '0) begin
      errors++;
      $display("FAIL reset_u0: got busy=%b done=%b bcd=%h neg=%b ovf=%b want all 0",
               busy0, done0, bcd0, neg0, ovf0);
    end
    checks++;
    if ({busy1, done1, bcd1, neg1, ovf1, busy2, done2, bcd2, neg2, ovf2} !== '0) begin
      errors++;
      $display("FAIL reset_u1u2: got bcd1=%h ovf1=%b bcd2=%h neg2=%b busy=%b%b want all 0",
               bcd1, ovf1, bcd2, neg2, busy1, busy2);
    end
    checks++;
    if ({busy3, done3, bcd3, neg3, ovf3, dbg0, dbg3} !== '0) begin
      errors++;
      $display("FAIL reset_u3: got busy=%b done=%b bcd=%h state=%b want all 0",
               busy3, done3, bcd3, dbg3);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One START pulse on the shared 16-bit inputs, then checks latency,
  // BUSY shape, results of all three instances and the single DONE pulse.
  task automatic conv16(input vec_t v);
    int lat;
    bit busy_ok;
    @(negedge clk);
    start16 = 1'b1;
    bin16   = v.bin;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    bin16   = ~v.bin;
    checks++;
    if ({busy0, busy1, busy2} !== 3'b111) begin
      errors++;
      $display("FAIL accept_busy(%h): got %b want 111", v.bin, {busy0, busy1, busy2});
    end
    lat = 0;
    busy_ok = 1'b1;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (done0) break;
      if (!busy0 || !busy1 || !busy2 || done1 || done2) busy_ok = 1'b0;
    end
    checks++;
    if (lat != 16 || !busy_ok) begin
      errors++;
      $display("FAIL latency(%h): got %0d busy_ok=%0d want 16 busy_ok=1", v.bin, lat, busy_ok);
    end
    checks++;
    if ({done1, done2, busy0, busy1, busy2} !== 5'b11000) begin
      errors++;
      $display("FAIL done_edge(%h): got done1/2=%b%b busy=%b want 11 000",
               v.bin, done1, done2, {busy0, busy1, busy2});
    end
    checks++;
    if (bcd0 !== v.e0 || ovf0 !== 1'b0 || neg0 !== 1'b0) begin
      errors++;
      $display("FAIL u0_result(%h): got %h ovf=%b neg=%b want %h ovf=0 neg=0",
               v.bin, bcd0, ovf0, neg0, v.e0);
    end
    checks++;
    if (bcd1 !== v.e1 || ovf1 !== v.e1_ovf || neg1 !== 1'b0) begin
      errors++;
      $display("FAIL u1_result(%h): got %h ovf=%b neg=%b want %h ovf=%b neg=0",
               v.bin, bcd1, ovf1, neg1, v.e1, v.e1_ovf);
    end
    checks++;
    if (bcd2 !== v.e2 || neg2 !== v.e2_neg || ovf2 !== 1'b0) begin
      errors++;
      $display("FAIL u2_result(%h): got %h neg=%b ovf=%b want %h neg=%b ovf=0",
               v.bin, bcd2, neg2, ovf2, v.e2, v.e2_neg);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({done0, done1, done2, busy0} !== 4'b0000 || bcd0 !== v.e0 || bcd2 !== v.e2) begin
      errors++;
      $display("FAIL pulse_hold(%h): got done=%b busy0=%b bcd0=%h bcd2=%h want 000 0 %h %h",
               v.bin, {done0, done1, done2}, busy0, bcd0, bcd2, v.e0, v.e2);
    end
  endtask

  task automatic test_directed();
    vec_t tbl[9];
    tbl[0] = '{16'd65535, 20'h65535, 16'h9999, 1'b1, 20'h00001, 1'b1};
    tbl[1] = '{16'd10000, 20'h10000, 16'h9999, 1'b1, 20'h10000, 1'b0};
    tbl[2] = '{16'd9999,  20'h09999, 16'h9999, 1'b0, 20'h09999, 1'b0};
    tbl[3] = '{16'h8000,  20'h32768, 16'h9999, 1'b1, 20'h32768, 1'b1};
    tbl[4] = '{16'h0000,  20'h00000, 16'h0000, 1'b0, 20'h00000, 1'b0};
    tbl[5] = '{16'd1234,  20'h01234, 16'h1234, 1'b0, 20'h01234, 1'b0};
    tbl[6] = '{16'd40000, 20'h40000, 16'h9999, 1'b1, 20'h25536, 1'b1};
    tbl[7] = '{16'd7,     20'h00007, 16'h0007, 1'b0, 20'h00007, 1'b0};
    tbl[8] = '{16'd59,    20'h00059, 16'h0059, 1'b0, 20'h00059, 1'b0};
    for (int i = 0; i < 9; i++) conv16(tbl[i]);
  endtask

  // START held high: a conversion is accepted again in the DONE cycle,
  // and BIN changes while BUSY never reach the result.
  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    start16 = 1'b1;
    bin16   = 16'd1234;
    @(posedge clk);
    #1;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (done0) break;
      if (lat == 5)  bin16 = 16'd7777;
      if (lat == 14) bin16 = 16'd1234;
    end
    checks++;
    if (lat != 16 || bcd0 !== 20'h01234 || bcd1 !== 16'h1234 || bcd2 !== 20'h01234) begin
      errors++;
      $display("FAIL b2b_first: got lat=%0d bcd0=%h bcd1=%h bcd2=%h want 16 01234 1234 01234",
               lat, bcd0, bcd1, bcd2);
    end
    @(posedge clk);
    #1;
    bin16 = 16'hFFFF;
    checks++;
    if (busy0 !== 1'b1 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b done=%b want 1 0", busy0, done0);
    end
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (done0) break;
    end
    start16 = 1'b0;
    checks++;
    if (lat != 16 || bcd0 !== 20'h01234 || ovf1 !== 1'b0 || neg2 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got lat=%0d bcd0=%h ovf1=%b neg2=%b want 16 01234 0 0",
               lat, bcd0, ovf1, neg2);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got busy=%b done=%b want 0 0", busy0, done0);
    end
  endtask

  task automatic test_reset_abort();
    vec_t a;
    vec_t b;
    bit   saw_done;
    a = '{16'd4321, 20'h04321, 16'h4321, 1'b0, 20'h04321, 1'b0};
    b = '{16'd999,  20'h00999, 16'h0999, 1'b0, 20'h00999, 1'b0};
    conv16(a);
    @(negedge clk);
    start16 = 1'b1;
    bin16   = 16'd999;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy0, done0, bcd0, neg0, ovf0, busy1, bcd1, busy2, bcd2} !== '0) begin
      errors++;
      $display("FAIL abort_clear: got busy0=%b bcd0=%h bcd1=%h bcd2=%h want all 0",
               busy0, bcd0, bcd1, bcd2);
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done0 || done1 || done2 || busy0) saw_done = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done0 || done1 || done2 || busy0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done || bcd0 !== 20'h0) begin
      errors++;
      $display("FAIL abort_no_done: got saw_done=%0d bcd0=%h want 0 00000", saw_done, bcd0);
    end
    conv16(b);
  endtask

  task automatic test_sweep8();
    int lat;
    int bad;
    bad = 0;
    for (int v = 0; v < 256; v++) begin
      @(negedge clk);
      start8 = 1'b1;
      bin8   = 8'(v);
      @(posedge clk);
      #1;
      start8 = 1'b0;
      bin8   = 8'(255 - v);
      lat = 0;
      while (lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
        if (done3) break;
      end
      checks++;
      if (lat != 8 || bcd3 !== dec3(v) || ovf3 !== 1'b0 || neg3 !== 1'b0) begin
        errors++;
        bad++;
        if (bad < 8)
          $display("FAIL sweep8(%0d): got lat=%0d bcd=%h ovf=%b neg=%b want 8 %h 0 0",
                   v, lat, bcd3, ovf3, neg3, dec3(v));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_abort();
    test_sweep8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
